// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request outstanding
        REQ   = 2'd1,   // live request outstanding
        DRAIN = 2'd2    // stale request outstanding, its response is dropped
    } fetch_state_t;

    // One queued instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0]  FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0]  PC_STEP        = 32'h0000_0004;
    localparam fetch_entry_t EMPTY_ENTRY    = '{pc: 32'h0000_0000, inst: 32'h0000_0000};

    // Fetch addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode. A flush empties the
// queue in the same cycle and overrides any push or pop requested with it.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t entry_in,
    output fetch_entry_t entry_out,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify push/pop: never write when full, never read when empty, ignore both on flush.
    always_comb begin
        push_ok_s = push && !flush && (count_r != CW'(DEPTH));
        pop_ok_s  = pop  && !flush && (count_r != {CW{1'b0}});
    end

    // Storage write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= EMPTY_ENTRY;
            end
        end else if (push_ok_s) begin
            mem_r[tail_r] <= entry_in;
        end
    end

    // Head/tail pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_ok_s) tail_r <= tail_r + PW'(1'b1);
            if (pop_ok_s)  head_r <= head_r + PW'(1'b1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign entry_out = mem_r[head_r];
    assign count     = count_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one cache request at a time, queues the
// returned words with their PCs, and handles redirects by flushing the
// queue and dropping the response of any request already in flight.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] addr,
    output logic        addr_valid,
    input  logic [31:0] data,
    input  logic        data_ready,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_r, next_state_s;
    logic [31:0]   pc_r, pc_next_s;
    logic [31:0]   addr_r, addr_next_s;
    logic          addr_valid_r;
    logic          started_r;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_after_push_s;
    logic [31:0]   target_s;
    fetch_entry_t  head_s;
    fetch_entry_t  push_entry_s;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (redirect),
        .entry_in  (push_entry_s),
        .entry_out (head_s),
        .count     (count_s)
    );

    // Next-state, PC and request address; the queue slot of the request in flight is already reserved.
    always_comb begin
        next_state_s       = state_r;
        pc_next_s          = pc_r;
        addr_next_s        = addr_r;
        push_s             = 1'b0;
        pop_s              = inst_ready && (count_s != {CW{1'b0}});
        target_s           = word_align(redirect_pc);
        push_entry_s       = '{pc: pc_r, inst: data};
        count_after_push_s = count_s + CW'(1'b1) - (pop_s ? CW'(1'b1) : CW'(1'b0));
        case (state_r)
            IDLE: begin
                // started_r holds off the first request for one edge after reset release.
                if (redirect) begin
                    pc_next_s = target_s;
                end else if (started_r && (count_s < CW'(DEPTH))) begin
                    next_state_s = REQ;
                    addr_next_s  = pc_r;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_next_s = target_s;
                    if (data_ready) begin
                        next_state_s = REQ;
                        addr_next_s  = target_s;
                    end else begin
                        next_state_s = DRAIN;
                    end
                end else if (data_ready) begin
                    push_s    = 1'b1;
                    pc_next_s = pc_r + PC_STEP;
                    if (count_after_push_s < CW'(DEPTH)) begin
                        next_state_s = REQ;
                        addr_next_s  = pc_r + PC_STEP;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = REQ;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_next_s = target_s;
                    if (data_ready) begin
                        next_state_s = REQ;
                        addr_next_s  = target_s;
                    end else begin
                        next_state_s = DRAIN;
                    end
                end else if (data_ready) begin
                    next_state_s = REQ;
                    addr_next_s  = pc_r;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, PC and registered cache request outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            addr_r       <= 32'h0000_0000;
            addr_valid_r <= 1'b0;
            started_r    <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            pc_r         <= pc_next_s;
            addr_r       <= addr_next_s;
            addr_valid_r <= (next_state_s != IDLE);
            started_r    <= 1'b1;
        end
    end

    assign addr       = addr_r;
    assign addr_valid = addr_valid_r;
    assign inst_valid = (count_s != {CW{1'b0}});
    assign inst       = head_s.inst;
    assign inst_pc    = head_s.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a scripted cache responder per scenario,
// with a scoreboard of expected queue entries pushed when a live response is
// driven and popped when decode sees the head.
module tb_inst_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] addr;
    logic        addr_valid;
    logic [31:0] data;
    logic        data_ready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int pass_cnt  = 0;
    int total_cnt = 0;
    fetch_entry_t sb[$];
    fetch_entry_t exp_e;

    inst_fetch #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .addr        (addr),
        .addr_valid  (addr_valid),
        .data        (data),
        .data_ready  (data_ready),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Hold reset over two edges, release at a falling edge.
    task automatic do_reset();
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        data = 32'h0; data_ready = 1'b0; inst_ready = 1'b0;
        sb.delete();
        tick(); tick();
        reset_n = 1'b1;
    endtask

    // Drive one live response for the current request and record it.
    task automatic respond(input logic [31:0] d);
        data = d; data_ready = 1'b1;
        sb.push_back('{pc: addr, inst: d});
        tick();
        data_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        tick();
        total_cnt++; if (addr_valid !== 1'b0) $display("FAIL rst_addr_valid got %b exp 0", addr_valid); else pass_cnt++;
        total_cnt++; if (addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", addr); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid got %b exp 0", inst_valid); else pass_cnt++;
        reset_n = 1'b1;
        tick();
        total_cnt++; if (addr_valid !== 1'b0) $display("FAIL rst_first_edge got %b exp 0", addr_valid); else pass_cnt++;
        tick();
        total_cnt++; if (addr_valid !== 1'b1 || addr !== RST_PC)
            $display("FAIL rst_first_req got %b/%h exp 1/%h", addr_valid, addr, RST_PC); else pass_cnt++;
    endtask

    task automatic test_sequential();
        inst_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                total_cnt++;
                if (sb.size() == 0) $display("FAIL seq_sb empty scoreboard at step %0d", i);
                else begin
                    exp_e = sb.pop_front();
                    if (inst_valid !== 1'b1 || inst_pc !== exp_e.pc || inst !== exp_e.inst)
                        $display("FAIL seq_head got %b/%h/%h exp 1/%h/%h", inst_valid, inst_pc, inst, exp_e.pc, exp_e.inst);
                    else pass_cnt++;
                end
            end
            if (i == 8) break;
            total_cnt++; if (addr_valid !== 1'b1 || addr !== 32'(i * 4))
                $display("FAIL seq_addr got %b/%h exp 1/%h", addr_valid, addr, 32'(i * 4)); else pass_cnt++;
            tick();
            total_cnt++; if (addr !== 32'(i * 4) || inst_valid !== 1'b0)
                $display("FAIL seq_hold got %h/%b exp %h/0", addr, inst_valid, 32'(i * 4)); else pass_cnt++;
            respond(NOP);
        end
    endtask

    task automatic test_backpressure();
        do_reset(); tick(); tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (addr_valid !== 1'b1 || addr !== 32'(i * 4))
                $display("FAIL bp_addr got %b/%h exp 1/%h", addr_valid, addr, 32'(i * 4)); else pass_cnt++;
            tick();
            respond(NOP);
        end
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (addr_valid !== 1'b0) $display("FAIL bp_full_idle got %b exp 0", addr_valid); else pass_cnt++;
            tick();
        end
        exp_e = sb.pop_front();
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== exp_e.pc)
            $display("FAIL bp_head got %b/%h exp 1/%h", inst_valid, inst_pc, exp_e.pc); else pass_cnt++;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        for (int w = 0; w < 4 && addr_valid !== 1'b1; w++) tick();
        total_cnt++; if (addr_valid !== 1'b1 || addr !== 32'h10)
            $display("FAIL bp_refill got %b/%h exp 1/00000010", addr_valid, addr); else pass_cnt++;
        total_cnt++; if (inst_pc !== sb[0].pc)
            $display("FAIL bp_next_head got %h exp %h", inst_pc, sb[0].pc); else pass_cnt++;
    endtask

    task automatic test_redirect_miss();
        do_reset(); tick(); tick();
        inst_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            respond(NOP);
        end
        sb.delete();
        total_cnt++; if (addr !== 32'h8) $display("FAIL rm_pre_addr got %h exp 00000008", addr); else pass_cnt++;
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        total_cnt++; if (addr !== 32'h8 || addr_valid !== 1'b1 || inst_valid !== 1'b0)
            $display("FAIL rm_drain got %h/%b/%b exp 00000008/1/0", addr, addr_valid, inst_valid); else pass_cnt++;
        tick();
        total_cnt++; if (addr !== 32'h8) $display("FAIL rm_hold got %h exp 00000008", addr); else pass_cnt++;
        data = 32'hDEAD_BEEF; data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        total_cnt++; if (addr !== 32'h100 || inst_valid !== 1'b0)
            $display("FAIL rm_target got %h/%b exp 00000100/0", addr, inst_valid); else pass_cnt++;
        tick();
        respond(NOP);
        exp_e = sb.pop_front();
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== exp_e.pc || inst !== exp_e.inst)
            $display("FAIL rm_first got %b/%h/%h exp 1/%h/%h", inst_valid, inst_pc, inst, exp_e.pc, exp_e.inst); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        inst_ready = 1'b0;
        tick();
        total_cnt++; if (inst_valid !== 1'b1) $display("FAIL sim_pre_valid got %b exp 1", inst_valid); else pass_cnt++;
        data = 32'h0000_0BAD; data_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h200;
        sb.delete();
        tick();
        data_ready = 1'b0; redirect = 1'b0;
        total_cnt++; if (addr !== 32'h200 || addr_valid !== 1'b1 || inst_valid !== 1'b0)
            $display("FAIL sim_after got %h/%b/%b exp 00000200/1/0", addr, addr_valid, inst_valid); else pass_cnt++;
        tick();
        respond(NOP);
        exp_e = sb.pop_front();
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== exp_e.pc)
            $display("FAIL sim_first got %b/%h exp 1/%h", inst_valid, inst_pc, exp_e.pc); else pass_cnt++;
    endtask

    task automatic test_wrap();
        // Low bits of the target are set on purpose; they must be ignored.
        data = 32'h0000_0BAD; data_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        sb.delete();
        tick();
        data_ready = 1'b0; redirect = 1'b0;
        total_cnt++; if (addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top got %h exp fffffffc", addr); else pass_cnt++;
        tick();
        respond(32'h1234_5678);
        total_cnt++; if (addr !== 32'h0000_0000) $display("FAIL wrap_zero got %h exp 00000000", addr); else pass_cnt++;
        exp_e = sb.pop_front();
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== exp_e.pc || inst !== exp_e.inst)
            $display("FAIL wrap_head got %b/%h/%h exp 1/%h/%h", inst_valid, inst_pc, inst, exp_e.pc, exp_e.inst); else pass_cnt++;
        tick();
        respond(NOP);
    endtask

    task automatic test_async_reset();
        total_cnt++; if (addr !== 32'h4 || inst_valid !== 1'b1)
            $display("FAIL ar_pre got %h/%b exp 00000004/1", addr, inst_valid); else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++; if (addr_valid !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL ar_immediate got %b/%b exp 0/0", addr_valid, inst_valid); else pass_cnt++;
        tick();
        reset_n = 1'b1;
        sb.delete();
        tick(); tick();
        total_cnt++; if (addr_valid !== 1'b1 || addr !== RST_PC)
            $display("FAIL ar_restart got %b/%h exp 1/%h", addr_valid, addr, RST_PC); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_miss();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
